data_memory_bus: RTL and testbench
==================================

# data_memory_bus

Parametrised data memory for the processor datapath, replacing the single-cycle word-only memory with a request/ready handshake, configurable wait states, and byte/halfword/word accesses. Loads support sign or zero extension. Misaligned, reserved-size and out-of-range accesses are flagged rather than silently aliased. The block sits between the MEM stage / load-store control and the storage array, and is the memory model against which multi-cycle and stalling pipeline controllers are developed.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of `endereco`.
- DEPTH, 256: number of 32-bit words; power of two, 4..65536.
- WAIT_STATES, 1: extra cycles per access, 0..15.

Ports:
- clock  in  1: single clock; all state updates on its rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- req  in  1: access request; fields below must be valid while req=1 in IDLE.
- we  in  1: 1 = store, 0 = load.
- size  in  2: 00 byte, 01 halfword, 10 word, 11 reserved.
- unsigned_load  in  1: 1 = zero-extend, 0 = sign-extend (byte/half loads only).
- endereco  in  ADDR_WIDTH: byte address.
- write_data  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- read_data  out  32: load result; valid only while ready=1, else 0.
- ready  out  1: one-cycle completion pulse.
- erro  out  1: qualifies ready; 1 = access rejected.

## Operation
- States: IDLE, BUSY. Reset: state IDLE, ready=0, erro=0, read_data=0, wait counter=0. Memory contents are not reset.
- IDLE, req=1 at a rising edge: the access is accepted. `we`, `size`, `unsigned_load`, `endereco` and `write_data` are captured, the counter loads WAIT_STATES, and the state moves to BUSY. Later changes to the inputs have no effect.
- BUSY, counter>0: decrement. `req` is ignored.
- BUSY, counter=0: the access executes. On the same edge: ready←1, state←IDLE.
- Error conditions (erro←1, no write, read_data←0):
  - half with endereco[0]=1;
  - word with endereco[1:0]≠0;
  - size=11;
  - any bit of endereco[ADDR_WIDTH-1 : log2(DEPTH)+2] set.
- Word index is endereco[log2(DEPTH)+1:2]; the lane is endereco[1:0].
- Store byte enables:
  - byte: the single lane selected by endereco[1:0];
  - half: lanes {1,0} or {3,2};
  - word: all four lanes.
  - Unselected bytes of the word are preserved.
- Load: select the lane(s), then extend to 32 bits per `unsigned_load`. Word loads ignore `unsigned_load`.
- Successful store: read_data=0.
- ready and erro are registered and high for exactly one cycle. In every other cycle ready=0, erro=0, read_data=0.
- A load immediately after a store to the same word returns the stored data.

## Timing
- Accept edge E0. Execute/commit edge E(WAIT_STATES+1). ready is visible in the cycle after that edge.
- Latency from accept to ready: WAIT_STATES+1 cycles.
- Back-to-back: if req=1 at the edge that ends the ready cycle, a new access is accepted there. Sustained throughput is one access per WAIT_STATES+2 cycles.
- Requester protocol: hold the fields until the accept edge. Drop req at the edge ending the ready cycle unless issuing a new access.
- reset_n low at any time forces the reset values immediately. An access reset before its commit edge performs no write.
- Reset deasserted with req=1: accepted at the first rising edge with reset_n high.

## Structure
- Shared package `data_memory_pkg`:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD encodings;
  - state encoding IDLE/BUSY;
  - localparam IDX_W = $clog2(DEPTH).
- Sub-module `byte_ram`: DEPTH×32 array with a 4-bit byte-write-enable, one write port and one combinational read port.
- Alignment checks, lane steering, extension, counter and FSM live in `data_memory_bus`.

## Test plan
- WAIT_STATES=1:
  - store word 0xDEADBEEF @0x10, then load word @0x10 → ready 2 cycles after each accept;
  - read_data=0xDEADBEEF, erro=0.
- Byte store/load:
  - store byte 0x80 @0x13 over 0x11223344 → word becomes 0x80223344;
  - signed byte load @0x13 → 0xFFFFFF80;
  - unsigned byte load → 0x00000080.
- Halfword:
  - store 0xBEEF @0x22 → upper half written;
  - signed half load @0x22 → 0xFFFFBEEF;
  - half load @0x21 → erro=1, read_data=0, memory unchanged.
- Errors, each with erro=1 and no write:
  - word store @0x402 with DEPTH=256;
  - size=11;
  - address 0x400 (out of range).
- Handshake:
  - WAIT_STATES=0, req held high for 4 accesses → ready every 2nd cycle;
  - field changes during BUSY do not alter the result.
- Reset: assert reset_n=0 during BUSY of a word store @0x30 → ready/erro/read_data=0 immediately; subsequent load @0x30 returns the old value.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared encodings and lane helpers for the data memory bus: access sizes,
// controller states, and the store-steering / load-extension functions.
package data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEPTH_DEFAULT = 256;
    localparam int IDX_W         = $clog2(DEPTH_DEFAULT);

    function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] lanes;
        case (size)
            SIZE_BYTE: lanes = 4'b0001 << lane;
            SIZE_HALF: lanes = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lanes = 4'b1111;
            default:   lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // Replicate right-aligned store data so every candidate lane sees it.
    function automatic logic [31:0] store_steer(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] steered;
        case (size)
            SIZE_BYTE: steered = {4{data[7:0]}};
            SIZE_HALF: steered = {2{data[15:0]}};
            default:   steered = data;
        endcase
        return steered;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic unsigned_load);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: result = unsigned_load ? {24'h000000, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = unsigned_load ? {16'h0000, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: result = word;
            default:   result = 32'h0000_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_memory_bus_byte_ram.sv
// DEPTH x 32 storage with per-byte write enables, one synchronous write port
// and one combinational read port. Contents are deliberately not reset.
module byte_ram #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [3:0]       byte_en,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];

    // Byte-granular write; lanes without an enable keep their contents
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_memory_bus.sv
// Handshaked data memory: captures a request, waits WAIT_STATES cycles, then
// commits the byte/half/word access and pulses ready (with erro on rejection).
module data_memory_bus
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_load,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    output logic                  erro
);

    localparam int         IDX_BITS  = $clog2(DEPTH);
    localparam int         TOP_LSB   = IDX_BITS + 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state_r;
    state_t                state_next_s;
    logic [3:0]            count_r;
    logic                  we_r;
    logic                  uns_r;
    logic [1:0]            size_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic                  ready_r;
    logic                  erro_r;
    logic [31:0]           rdata_r;

    logic                  accept_s;
    logic                  execute_s;
    logic                  bad_shape_s;
    logic                  range_s;
    logic                  fault_s;
    logic                  write_en_s;
    logic [1:0]            lane_s;
    logic [IDX_BITS-1:0]   index_s;
    logic [3:0]            byte_en_s;
    logic [31:0]           ram_wdata_s;
    logic [31:0]           ram_rdata_s;
    logic [31:0]           load_value_s;

    // Address bits above the array must be zero, otherwise the access would alias
    generate
        if (ADDR_WIDTH > TOP_LSB) begin : g_range
            assign range_s = |addr_r[ADDR_WIDTH-1:TOP_LSB];
        end else begin : g_no_range
            assign range_s = 1'b0;
        end
    endgenerate

    // Classify the captured access and derive lane controls for the array
    always_comb begin
        lane_s   = addr_r[1:0];
        index_s  = addr_r[TOP_LSB-1:2];
        accept_s = (state_r == IDLE) && req;
        case (size_r)
            SIZE_BYTE: bad_shape_s = 1'b0;
            SIZE_HALF: bad_shape_s = addr_r[0];
            SIZE_WORD: bad_shape_s = |addr_r[1:0];
            default:   bad_shape_s = 1'b1;
        endcase
        fault_s      = bad_shape_s | range_s;
        execute_s    = (state_r == BUSY) && (count_r == 4'd0);
        write_en_s   = execute_s & we_r & ~fault_s;
        byte_en_s    = write_en_s ? store_lanes(size_r, lane_s) : 4'b0000;
        ram_wdata_s  = store_steer(size_r, wdata_r);
        load_value_s = load_extend(ram_rdata_s, size_r, lane_s, uns_r);
    end

    // Next-state logic: one wait phase per access, then back to IDLE on commit
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (count_r == 4'd0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture and wait-state countdown
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 4'd0;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= SIZE_BYTE;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            count_r <= WAIT_INIT;
            we_r    <= we;
            uns_r   <= unsigned_load;
            size_r  <= size;
            addr_r  <= endereco;
            wdata_r <= write_data;
        end else if ((state_r == BUSY) && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Completion outputs: high for the single cycle after the commit edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b0;
            erro_r  <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else if (execute_s) begin
            ready_r <= 1'b1;
            erro_r  <= fault_s;
            rdata_r <= (we_r | fault_s) ? 32'h0000_0000 : load_value_s;
        end else begin
            ready_r <= 1'b0;
            erro_r  <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end
    end

    byte_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_BITS)
    ) u_ram (
        .clock   (clock),
        .byte_en (byte_en_s),
        .waddr   (index_s),
        .wdata   (ram_wdata_s),
        .raddr   (index_s),
        .rdata   (ram_rdata_s)
    );

    assign read_data = rdata_r;
    assign ready     = ready_r;
    assign erro      = erro_r;

endmodule

// File: tb/tb_data_memory_bus.sv
// Randomized self-checking bench for data_memory_bus against a byte-level
// reference model; a second instance with zero wait states covers streaming.
module tb_data_memory_bus;

    localparam int DEPTH_TB = 256;
    localparam int WS1      = 1;

    logic        clock;
    logic        reset_n;
    logic        req, we, unsigned_load;
    logic [1:0]  size;
    logic [31:0] endereco, write_data, read_data;
    logic        ready, erro;

    logic        req0, we0, uns0;
    logic [1:0]  size0;
    logic [31:0] addr0, wd0, rd0;
    logic        ready0, erro0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH_TB];
    logic [31:0] hs_val [4];

    data_memory_bus #(.ADDR_WIDTH(32), .DEPTH(DEPTH_TB), .WAIT_STATES(WS1)) u_dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .unsigned_load(unsigned_load), .endereco(endereco), .write_data(write_data),
        .read_data(read_data), .ready(ready), .erro(erro)
    );

    data_memory_bus #(.ADDR_WIDTH(32), .DEPTH(DEPTH_TB), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .we(we0), .size(size0),
        .unsigned_load(uns0), .endereco(addr0), .write_data(wd0),
        .read_data(rd0), .ready(ready0), .erro(erro0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: byte-addressed memory with alignment and range rules
    function automatic void model_access(input logic w, input logic [1:0] sz, input logic u,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic e, output logic [31:0] rd);
        int          idx, lane, nbytes;
        logic [31:0] word;
        e  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
             || (a >= 32'(DEPTH_TB * 4));
        rd = 32'd0;
        if (!e) begin
            idx    = int'(a / 4);
            lane   = int'(a % 4);
            nbytes = 1 << sz;
            word   = mem_m[idx];
            if (w) begin
                for (int i = 0; i < nbytes; i++) word[8*(lane+i) +: 8] = wd[8*i +: 8];
                mem_m[idx] = word;
            end else begin
                for (int i = 0; i < nbytes; i++) rd[8*i +: 8] = word[8*(lane+i) +: 8];
                if (!u && nbytes < 4 && rd[8*nbytes-1])
                    for (int i = nbytes; i < 4; i++) rd[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] got, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        we = w; size = sz; unsigned_load = u; endereco = a; write_data = wd; req = 1'b1;
        @(posedge clock);
        model_access(w, sz, u, a, wd, exp_err, exp_rd);
        @(negedge clock);
        req = 1'b0;
        we = 1'($urandom); size = 2'($urandom); unsigned_load = 1'($urandom);
        endereco = $urandom; write_data = $urandom;
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        got     = read_data;
        got_err = erro;
        check_val("latency", 32'(lat), 32'(WS1 + 1));
        check_val("ready", {31'd0, ready}, 32'd1);
        check_val("erro", {31'd0, erro}, {31'd0, exp_err});
        check_val("read_data", read_data, exp_rd);
    endtask

    task automatic set_hs_fields(input int k);
        we0 = (k < 4); size0 = 2'b10; uns0 = 1'b0;
        addr0 = 32'((k % 4) * 4); wd0 = hs_val[k % 4];
    endtask

    logic [31:0] got;
    logic        e;
    logic [1:0]  sz;
    logic [31:0] a;

    initial begin
        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'b00; unsigned_load = 1'b0; endereco = 32'd0; write_data = 32'd0;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; uns0 = 1'b0; addr0 = 32'd0; wd0 = 32'd0;
        repeat (3) @(negedge clock);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_erro", {31'd0, erro}, 32'd0);
        check_val("rst_rdata", read_data, 32'd0);
        check_val("rst_ready0", {31'd0, ready0}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH_TB; i++) do_access(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, got, e);

        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got, e);
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, e);
        check_val("word_load", got, 32'hDEADBEEF);

        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, got, e);
        do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, got, e);
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, e);
        check_val("byte_merge", got, 32'h80223344);
        do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got, e);
        check_val("byte_signed", got, 32'hFFFFFF80);
        do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got, e);
        check_val("byte_unsigned", got, 32'h00000080);

        do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, got, e);
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, got, e);
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got, e);
        check_val("half_upper", got, 32'hBEEF5678);
        do_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, got, e);
        check_val("half_signed", got, 32'hFFFFBEEF);
        do_access(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000AAAA, got, e);
        check_val("half_misalign_err", {31'd0, e}, 32'd1);
        do_access(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, got, e);
        check_val("half_misalign_rd", got, 32'd0);
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got, e);
        check_val("half_unchanged", got, 32'hBEEF5678);

        do_access(1'b1, 2'b10, 1'b0, 32'h402, 32'hAAAA5555, got, e);
        check_val("oor_misalign_err", {31'd0, e}, 32'd1);
        do_access(1'b1, 2'b11, 1'b0, 32'h40, 32'hAAAA5555, got, e);
        check_val("rsvd_err", {31'd0, e}, 32'd1);
        do_access(1'b1, 2'b10, 1'b0, 32'h400, 32'hAAAA5555, got, e);
        check_val("oor_err", {31'd0, e}, 32'd1);
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, got, e);
        do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got, e);

        // Reset during a ready cycle, then during BUSY of a store
        do_access(1'b1, 2'b10, 1'b0, 32'h30, 32'h5A5A1234, got, e);
        do_access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, got, e);
        reset_n = 1'b0;
        #1;
        check_val("rst_imm_ready", {31'd0, ready}, 32'd0);
        check_val("rst_imm_rdata", read_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        we = 1'b1; size = 2'b10; unsigned_load = 1'b0; endereco = 32'h30; write_data = 32'hCAFEF00D; req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_val("rst_busy_ready", {31'd0, ready}, 32'd0);
        check_val("rst_busy_erro", {31'd0, erro}, 32'd0);
        check_val("rst_busy_rdata", read_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        do_access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, got, e);
        check_val("rst_no_write", got, 32'h5A5A1234);

        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = $urandom;
            do_access(1'($urandom), sz, 1'($urandom), a, $urandom, got, e);
        end

        // Zero-wait-state instance: req held high across stores then loads
        for (int i = 0; i < 4; i++) hs_val[i] = $urandom;
        @(negedge clock);
        set_hs_fields(0);
        req0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            check_val("hs_busy_ready", {31'd0, ready0}, 32'd0);
            if (k < 7) begin
                set_hs_fields(k + 1);
            end else begin
                req0 = 1'b0;
                addr0 = $urandom;
                wd0 = $urandom;
            end
            @(negedge clock);
            check_val("hs_ready", {31'd0, ready0}, 32'd1);
            check_val("hs_erro", {31'd0, erro0}, 32'd0);
            check_val("hs_rdata", rd0, (k < 4) ? 32'd0 : hs_val[k - 4]);
        end
        @(negedge clock);
        check_val("hs_idle", {31'd0, ready0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
